key_search_sequencer: RTL and testbench

Master controller for the RC4 key-search flow. It drives the `mode` select and the candidate `key` into the RAM controller, which owns the initializer, shuffler and decryptor and exposes their done flags on `finish_bus`. For each candidate key it runs three phases in order: S-RAM init, shuffle, then decrypt. It then reads the decryptor's `success` flag and either stops on a hit or advances to the next key until the range is exhausted.

---
 rtl/key_search_sequencer.sv | 90 +++++++++
 tb/tb_key_search_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/key_search_sequencer.sv
// key_search_sequencer: RC4 key-search master FSM stepping each candidate key through init, shuffle and decrypt phases
module key_search_sequencer #(
  parameter int RAM_WIDTH   = 8,
  parameter int KEY_LENGTH  = 3,
  parameter int NUM_DEVICES = 3,
  parameter int KEY_BITS    = 22,
  parameter int KEY_START   = 0,
  parameter int KEY_END     = 2**KEY_BITS-1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [NUM_DEVICES-1:0]                finish_bus,
  input  logic                                  success,
  output logic [5:0]                            mode,
  output logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0]  key,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  found,
  output logic [KEY_BITS-1:0]                   key_count
);
  localparam int KW = KEY_LENGTH*RAM_WIDTH;
  localparam logic [5:0] M_IDLE = 6'b000_000;
  localparam logic [5:0] M_INIT = 6'b001_000;
  localparam logic [5:0] M_SHUF = 6'b010_000;
  localparam logic [5:0] M_DECR = 6'b011_000;
  localparam logic [5:0] M_DONE = 6'b100_000;
  localparam logic [KEY_BITS-1:0] K_START = KEY_BITS'(KEY_START);
  localparam logic [KEY_BITS-1:0] K_END   = KEY_BITS'(KEY_END);
  typedef enum logic [3:0] {IDLE, INIT, GAP1, SHUF, GAP2, DECR, GAP3, NEXT, DONE} state_t;
  state_t r_state, w_next;
  logic [5:0] r_mode, w_mode;
  logic [KEY_BITS-1:0] r_key_count;
  logic r_busy, r_done, r_found, r_hit;
  logic [KW-1:0] w_key;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = start ? INIT : IDLE;
      INIT: w_next = finish_bus[0] ? GAP1 : INIT;
      GAP1: w_next = finish_bus[0] ? GAP1 : SHUF;
      SHUF: w_next = finish_bus[1] ? GAP2 : SHUF;
      GAP2: w_next = finish_bus[1] ? GAP2 : DECR;
      DECR: w_next = finish_bus[2] ? GAP3 : DECR;
      GAP3: w_next = finish_bus[2] ? GAP3 : (r_hit || r_key_count == K_END) ? DONE : NEXT;
      NEXT: w_next = INIT;
      DONE: w_next = start ? INIT : DONE;
      default: w_next = IDLE;
    endcase
  end
  // mode is registered from the next state so it lines up with the state register
  always_comb begin
    w_mode = (w_next == INIT) ? M_INIT :
             (w_next == SHUF) ? M_SHUF :
             (w_next == DECR) ? M_DECR :
             (w_next == DONE) ? M_DONE : M_IDLE;
    w_key = '0;
    w_key[KEY_BITS-1:0] = r_key_count;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mode      <= M_IDLE;
      r_key_count <= K_START;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_found     <= 1'b0;
      r_hit       <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mode  <= w_mode;
      r_busy  <= (w_next != IDLE) && (w_next != DONE);
      r_done  <= (w_next == DONE);
      if ((r_state == IDLE || r_state == DONE) && start) begin
        r_key_count <= K_START;
        r_found     <= 1'b0;
      end
      if (r_state == DECR && finish_bus[2]) r_hit <= success;
      // increment on entry to NEXT so the key settles a cycle before INIT
      if (r_state == GAP3 && w_next == NEXT) r_key_count <= r_key_count + KEY_BITS'(1);
      if (r_state == GAP3 && w_next == DONE) r_found <= r_hit;
    end
  end
  assign mode      = r_mode;
  assign key       = w_key;
  assign busy      = r_busy;
  assign done      = r_done;
  assign found     = r_found;
  assign key_count = r_key_count;
endmodule

// File: tb/tb_key_search_sequencer.sv
// tb_key_search_sequencer: directed table plus stub-device sequences for key_search_sequencer
module tb_key_search_sequencer;
  localparam logic [5:0] M_INIT = 6'h08;
  localparam logic [5:0] M_SHUF = 6'h10;
  localparam logic [5:0] M_DECR = 6'h18;
  localparam logic [5:0] M_DONE = 6'h20;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic [2:0] finish_bus, fb_man, fb_stub;
  logic success, man_success;
  logic [5:0] mode;
  logic [2:0][7:0] key;
  logic busy, done, found;
  logic [21:0] key_count;
  logic stub_en = 1'b0;
  logic hit_en = 1'b0;
  logic [21:0] hit_key = 22'd0;
  int cnt;
  int tests = 0;
  int fails = 0;
  logic [5:0] modes[$];
  logic [21:0] keys[$];

  key_search_sequencer #(.KEY_START(0), .KEY_END(3)) dut (
    .clk(clk), .reset(reset), .start(start), .finish_bus(finish_bus), .success(success),
    .mode(mode), .key(key), .busy(busy), .done(done), .found(found), .key_count(key_count)
  );

  always #5 clk = ~clk;
  assign finish_bus = stub_en ? fb_stub : fb_man;
  assign success = stub_en ? (hit_en && key_count == hit_key) : man_success;

  // stub devices: finish 5 cycles after their mode appears, drop 1 cycle after mode goes idle
  always @(posedge clk) begin
    if (reset || !stub_en) begin
      cnt <= 0;
      fb_stub <= 3'b000;
    end else if (mode == M_INIT || mode == M_SHUF || mode == M_DECR) begin
      if (cnt == 4) fb_stub[int'(mode[4:3]) - 1] <= 1'b1;
      else cnt <= cnt + 1;
    end else begin
      cnt <= 0;
      fb_stub <= 3'b000;
    end
  end

  typedef struct {
    logic        st;
    logic [2:0]  fb;
    logic        sc;
    logic [5:0]  m;
    logic        b;
    logic        d;
    logic        f;
    logic [21:0] kc;
  } vec_t;
  vec_t vecs[19];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_search(input int max);
    logic [5:0] prev;
    prev = mode;
    modes.delete();
    keys.delete();
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < max; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (mode != prev && mode != 6'h00) modes.push_back(mode);
      if (mode == M_INIT && prev != M_INIT) keys.push_back(key_count);
      prev = mode;
      if (done) break;
    end
    check("search_reaches_done", 64'(done), 64'd1);
  endtask

  initial begin
    logic [5:0] exp_modes[$];
    bit ok;
    vecs[0]  = '{1'b0, 3'b000, 1'b0, 6'h00, 1'b0, 1'b0, 1'b0, 22'd0};
    vecs[1]  = '{1'b1, 3'b000, 1'b0, M_INIT, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[2]  = '{1'b0, 3'b100, 1'b0, M_INIT, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[3]  = '{1'b0, 3'b010, 1'b0, M_INIT, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[4]  = '{1'b0, 3'b001, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[5]  = '{1'b0, 3'b001, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[6]  = '{1'b0, 3'b001, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[7]  = '{1'b0, 3'b001, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[8]  = '{1'b0, 3'b001, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[9]  = '{1'b0, 3'b000, 1'b0, M_SHUF, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[10] = '{1'b0, 3'b101, 1'b0, M_SHUF, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[11] = '{1'b0, 3'b010, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[12] = '{1'b0, 3'b000, 1'b0, M_DECR, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[13] = '{1'b1, 3'b000, 1'b0, M_DECR, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[14] = '{1'b0, 3'b011, 1'b1, M_DECR, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[15] = '{1'b0, 3'b100, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[16] = '{1'b0, 3'b100, 1'b1, 6'h00, 1'b1, 1'b0, 1'b0, 22'd0};
    vecs[17] = '{1'b0, 3'b000, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0, 22'd1};
    vecs[18] = '{1'b0, 3'b000, 1'b0, M_INIT, 1'b1, 1'b0, 1'b0, 22'd1};
    fb_man = 3'b000;
    man_success = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 64'({mode, busy, done, found, key_count}), 64'({6'h00, 3'b000, 22'd0}));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      start = vecs[i].st;
      fb_man = vecs[i].fb;
      man_success = vecs[i].sc;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), 64'({mode, busy, done, found, key_count}),
            64'({vecs[i].m, vecs[i].b, vecs[i].d, vecs[i].f, vecs[i].kc}));
    end
    @(negedge clk);
    start = 1'b0;
    fb_man = 3'b000;
    stub_en = 1'b1;
    do_reset();
    run_search(1000);
    for (int p = 0; p < 4; p++) exp_modes = {exp_modes, M_INIT, M_SHUF, M_DECR};
    exp_modes.push_back(M_DONE);
    ok = modes.size() == exp_modes.size();
    for (int i = 0; ok && i < exp_modes.size(); i++) ok = modes[i] == exp_modes[i];
    check("full_mode_seq", 64'({ok, 32'(modes.size())}), 64'({1'b1, 32'd13}));
    ok = keys.size() == 4;
    for (int i = 0; ok && i < 4; i++) ok = keys[i] == 22'(i);
    check("full_key_seq", 64'({ok, 32'(keys.size())}), 64'({1'b1, 32'd4}));
    check("full_done_state", 64'({mode, busy, done, found, key_count}), 64'({M_DONE, 3'b010, 22'd3}));
    repeat (3) @(posedge clk);
    #1;
    check("done_holds", 64'({mode, busy, done, found, key_count}), 64'({M_DONE, 3'b010, 22'd3}));
    hit_en = 1'b1;
    hit_key = 22'd2;
    do_reset();
    run_search(1000);
    check("hit_init_count", 64'(keys.size()), 64'd3);
    check("hit_key", 64'(24'(key)), 64'h000002);
    check("hit_done_state", 64'({mode, busy, done, found, key_count}), 64'({M_DONE, 3'b011, 22'd2}));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    check("restart_from_done", 64'({mode, busy, done, found, key_count}), 64'({M_INIT, 3'b100, 22'd0}));
    hit_en = 1'b0;
    do_reset();
    @(negedge clk);
    start = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      ok = (mode == M_SHUF && key_count == 22'd1);
    end
    check("reach_second_shuf", 64'(ok), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_shuf", 64'({mode, busy, key_count}), 64'({6'h00, 1'b0, 22'd0}));
    @(negedge clk);
    reset = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
